// File: rtl/seq_alu_pkg.sv
// Shared opcode and state encodings for the registered, handshaked ALU.
// Optional status flags are enabled elsewhere with the SEQ_ALU_FLAGS_EN macro.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_ADD2  = 3'd2;
  localparam logic [2:0] OP_SUB2  = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_MIN   = 3'd5;
  localparam logic [2:0] OP_PASSA = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative W-step shift-add multiplier datapath. One multiplier bit is
// consumed per clock; o_done/o_product are valid during the final step's cycle.
module shift_add_mul #(
  parameter int W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic           r_busy;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;

  logic           w_last;
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_acc_next;

  assign w_last     = r_busy && (r_cnt == CW'(W - 1));
  assign w_addend   = r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;

  // The product is taken from the adder output so the caller can register it
  // on the same edge as the final step.
  assign o_done    = w_last;
  assign o_product = w_acc_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered valid/ready ALU with eight ops and an iterative multiplier.
// Define SEQ_ALU_FLAGS_EN to add registered zero/borrow status outputs.
//
// state   | meaning
// IDLE    | no result held, ready for an op
// BUSY    | multiply iterating, inputs ignored
// HOLD    | result held until consumed
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [2:0]     i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_out_valid,
  input  logic           i_out_ready,
`ifdef SEQ_ALU_FLAGS_EN
  output logic           o_flag_zero,
  output logic           o_flag_borrow,
`endif
  output logic [2*W-1:0] o_result
);

  logic [1:0]     r_state;
  logic [2*W-1:0] r_result;

  logic           w_accept;
  logic           w_is_mul;
  logic           w_mul_start;
  logic           w_mul_done;
  logic [2*W-1:0] w_product;
  logic [2*W-1:0] w_ax;
  logic [2*W-1:0] w_bx;
  logic [2*W-1:0] w_bx2;
  logic [2*W-1:0] w_alu;

  assign o_in_ready  = (r_state == ST_IDLE) ||
                       ((r_state == ST_HOLD) && i_out_ready);
  assign o_out_valid = (r_state == ST_HOLD);
  assign o_result    = r_result;

  assign w_accept    = i_in_valid && o_in_ready;
  assign w_is_mul    = (i_op == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;

  assign w_ax  = {{W{1'b0}}, i_a};
  assign w_bx  = {{W{1'b0}}, i_b};
  assign w_bx2 = w_bx << 1;

  always_comb begin
    w_alu = '0;
    case (i_op)
      OP_ADD:   w_alu = w_ax + w_bx;
      OP_SUB:   w_alu = w_ax - w_bx;
      OP_ADD2:  w_alu = w_ax + w_bx2;
      OP_SUB2:  w_alu = w_ax - w_bx2;
      OP_MIN:   w_alu = (i_a < i_b) ? w_ax : w_bx;
      OP_PASSA: w_alu = w_ax;
      OP_PASSB: w_alu = w_bx;
      default:  w_alu = '0;
    endcase
  end

  shift_add_mul #(.W(W)) u_mul (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_mul_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_BUSY: begin
          if (w_mul_done) begin
            r_result <= w_product;
            r_state  <= ST_HOLD;
          end
        end
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= ST_BUSY;
            end else begin
              r_result <= w_alu;
              r_state  <= ST_HOLD;
            end
          end else if ((r_state == ST_HOLD) && i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic r_flag_zero;
  logic r_flag_borrow;
  logic w_borrow;

  // Borrow compares the zero-extended operands, so SUB2 sees the full 2b.
  assign w_borrow = ((i_op == OP_SUB)  && (w_ax < w_bx)) ||
                    ((i_op == OP_SUB2) && (w_ax < w_bx2));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flag_zero   <= 1'b0;
      r_flag_borrow <= 1'b0;
    end else if ((r_state == ST_BUSY) && w_mul_done) begin
      r_flag_zero   <= (w_product == '0);
      r_flag_borrow <= 1'b0;
    end else if (w_accept && !w_is_mul && (r_state != ST_BUSY)) begin
      r_flag_zero   <= (w_alu == '0);
      r_flag_borrow <= w_borrow;
    end
  end

  assign o_flag_zero   = r_flag_zero;
  assign o_flag_borrow = r_flag_borrow;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus randomized traffic
// scored against an arithmetic reference model and a transaction queue.
module tb_seq_alu;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
`ifdef SEQ_ALU_FLAGS_EN
  logic           flag_zero;
  logic           flag_borrow;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2*W-1:0] res;
    logic           zero;
    logic           borrow;
  } exp_t;

  exp_t q[$];

  seq_alu #(.W(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
`ifdef SEQ_ALU_FLAGS_EN
    .o_flag_zero   (flag_zero),
    .o_flag_borrow (flag_borrow),
`endif
    .o_result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned ax;
    longint unsigned by;
    longint unsigned r;
    exp_t e;
    ax = 64'(x);
    by = 64'(y);
    case (o)
      3'd0:    r = ax + by;
      3'd1:    r = ax - by;
      3'd2:    r = ax + 2 * by;
      3'd3:    r = ax - 2 * by;
      3'd4:    r = ax * by;
      3'd5:    r = (ax < by) ? ax : by;
      3'd6:    r = ax;
      default: r = by;
    endcase
    e.res    = r[2*W-1:0];
    e.zero   = (e.res == '0);
    e.borrow = ((o == 3'd1) && (ax < by)) || ((o == 3'd3) && (ax < 2 * by));
    return e;
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic consume_check();
    exp_t e;
    if (q.size() == 0) begin
      check("rnd_spurious_valid", 64'(1), 64'(0));
    end else begin
      e = q.pop_front();
      check("rnd_result", 64'(result), 64'(e.res));
`ifdef SEQ_ALU_FLAGS_EN
      check("rnd_flag_zero", 64'(flag_zero), 64'(e.zero));
      check("rnd_flag_borrow", 64'(flag_borrow), 64'(e.borrow));
`endif
    end
  endtask

  logic [2:0] dir_ops [7];
  logic [7:0] dir_exp [7];

  initial begin
    dir_ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    dir_exp = '{8'h0C, 8'h06, 8'h0F, 8'h03, 8'h03, 8'h09, 8'h03};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    clk_step();
    check("idle_in_ready", 64'(in_ready), 64'(1));
    check("idle_out_valid", 64'(out_valid), 64'(0));
    check("idle_result", 64'(result), 64'(0));

    // Back-to-back single-cycle ops, a=9 b=3
    out_ready = 1'b1;
    a = 4'd9; b = 4'd3;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      op = dir_ops[i];
      clk_step();
      check("b2b_out_valid", 64'(out_valid), 64'(1));
      check("b2b_result", 64'(result), 64'(dir_exp[i]));
      check("b2b_in_ready", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    clk_step();
    check("b2b_drain_idle", 64'(out_valid), 64'(0));

    // Multiply 15*15: four busy cycles, then the product
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd4; a = 4'd15; b = 4'd15;
    clk_step();
    in_valid = 1'b1; op = 3'd0; a = 4'd1; b = 4'd1;
    for (int i = 0; i < W; i++) begin
      check("mul_busy_in_ready", 64'(in_ready), 64'(0));
      check("mul_busy_out_valid", 64'(out_valid), 64'(0));
      clk_step();
    end
    check("mul_out_valid", 64'(out_valid), 64'(1));
    check("mul_result", 64'(result), 64'(8'hE1));
    in_valid = 1'b0;
    out_ready = 1'b1;
    clk_step();
    check("mul_consumed", 64'(out_valid), 64'(0));

    // Back-pressure: result held while out_ready low, then accept+consume
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; a = 4'd2; b = 4'd5;
    clk_step();
    a = 4'd1; b = 4'd1;
    for (int i = 0; i < 3; i++) begin
      check("bp_result", 64'(result), 64'(8'h07));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      clk_step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    clk_step();
    check("bp_new_result", 64'(result), 64'(8'h02));
    check("bp_out_valid_kept", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    clk_step();

`ifdef SEQ_ALU_FLAGS_EN
    in_valid = 1'b1; op = 3'd1; a = 4'd3; b = 4'd5;
    clk_step();
    check("sub_under_result", 64'(result), 64'(8'hFE));
    check("sub_under_borrow", 64'(flag_borrow), 64'(1));
    check("sub_under_zero", 64'(flag_zero), 64'(0));
    a = 4'd5; b = 4'd5;
    clk_step();
    check("sub_eq_result", 64'(result), 64'(8'h00));
    check("sub_eq_zero", 64'(flag_zero), 64'(1));
    check("sub_eq_borrow", 64'(flag_borrow), 64'(0));
    in_valid = 1'b0;
    clk_step();
`endif

    // Load a nonzero result, then abort a multiply with reset
    in_valid = 1'b1; op = 3'd6; a = 4'd9; b = 4'd0;
    clk_step();
    check("pre_abort_result", 64'(result), 64'(8'h09));
    op = 3'd4; a = 4'd7; b = 4'd6;
    clk_step();
    in_valid = 1'b0;
    clk_step();
    clk_step();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      clk_step();
      check("abort_no_valid", 64'(out_valid), 64'(0));
    end
    check("abort_result_after", 64'(result), 64'(0));

    // Randomized traffic scored through the expectation queue
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) consume_check();
      if (in_valid && in_ready) q.push_back(ref_model(op, a, b));
      clk_step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (out_valid) consume_check();
      clk_step();
    end
    check("rnd_queue_drained", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, handshaked, width-parametrised ALU: the sequential successor to the team's combinational 3-bit-opcode ALU. It keeps the same eight operations and adds valid/ready flow control, a registered result, and an iterative shift-add multiplier in place of the combinational array multiplier. It sits between an operand-issuing controller and any result consumer that can apply back-pressure.

## Interface
- `W`, default 4: operand width in bits; result width is 2W; legal range 2–32.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous reset, active-low.
- `in_valid  in  1`: `op`, `a` and `b` are presented.
- `in_ready  out  1`: block can accept an operation this cycle.
- `op  in  3`: operation select.
- `a  in  W`: operand A, unsigned.
- `b  in  W`: operand B, unsigned.
- `out_valid  out  1`: `result` holds a completed operation.
- `out_ready  in  1`: consumer takes the result this cycle.
- `result  out  2W`: registered result.
- `flag_zero  out  1`: result == 0. Present only with `SEQ_ALU_FLAGS_EN`.
- `flag_borrow  out  1`: subtraction underflowed. Present only with `SEQ_ALU_FLAGS_EN`.

## Operation
- Operands are zero-extended to 2W bits. All arithmetic is modulo 2^(2W).
- Opcodes:
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 ADD2: a+2b
  - 3 SUB2: a−2b
  - 4 MUL: a·b, unsigned
  - 5 MIN: the unsigned smaller of a and b
  - 6 PASSA: a
  - 7 PASSB: b
- Transfers:
  - An input is accepted on any edge where `in_valid & in_ready`.
  - A result is consumed on any edge where `out_valid & out_ready`.
- States:
  - IDLE: no result is held.
  - BUSY: a multiply is iterating.
  - HOLD: a result is held.
- Handshake outputs:
  - `in_ready = IDLE | (HOLD & out_ready)`.
  - `out_valid = HOLD`.
- Transitions:
  - IDLE or HOLD, accepting a non-MUL op: the result is computed and registered, and the state becomes HOLD.
  - IDLE or HOLD, accepting MUL: the multiplier is loaded with accumulator 0, counter 0, multiplicand a and multiplier b, and the state becomes BUSY.
  - BUSY: each edge performs one shift-add step on multiplier bit `counter` and increments `counter`. On the edge where `counter == W−1`, the final product is written to `result` and the state becomes HOLD.
  - HOLD & out_ready with no accept: the state becomes IDLE. `result` keeps its last value.
  - HOLD with `!out_ready`: `result` and flags are stable and `in_ready` is 0.
- Inputs are ignored while BUSY. They need not be held after acceptance, because operands are captured.
- Asserting `rst_n` low at any time aborts an in-flight multiply. The aborted result is never presented.

## Timing
- Reset values:
  - State is IDLE, so `in_ready` is 1.
  - `out_valid` is 0.
  - `result` is 0.
  - Counter, accumulator and flags are 0.
- Latency, measured from the accept edge to the first cycle with `out_valid` high:
  - Non-MUL ops: 1 cycle.
  - MUL: W+1 cycles. The accept edge is followed by W iteration edges.
- Throughput:
  - Non-MUL ops: 1 per cycle when the consumer holds `out_ready` high, because accept and consume can happen on the same edge.
  - MUL: 1 per W+1 cycles.
- On a simultaneous consume and accept in HOLD, the new result replaces the old one on the same edge and `out_valid` stays high.
- `result` changes only on an accept edge of a non-MUL op, on the final BUSY edge, or on reset.

## Configuration
- `SEQ_ALU_FLAGS_EN` defined:
  - The `flag_zero` and `flag_borrow` ports exist and are registered alongside `result`.
  - `flag_borrow` is 1 only for SUB when a<b and for SUB2 when a<2b. It is 0 for all other ops.
  - Both flags reset to 0.
- `SEQ_ALU_FLAGS_EN` undefined: both ports and their registers are absent. All other behaviour is identical.

## Structure
- Package `seq_alu_pkg` holds:
  - The opcode localparams `OP_ADD`, `OP_SUB`, `OP_ADD2`, `OP_SUB2`, `OP_MUL`, `OP_MIN`, `OP_PASSA` and `OP_PASSB`.
  - The state encoding `ST_IDLE`, `ST_BUSY` and `ST_HOLD`.
- One sub-module, `shift_add_mul`:
  - Holds the W-step iterative multiplier datapath with its own counter.
  - Interface: start, operands, done pulse, 2W product.
  - Control stays in `seq_alu`.

## Test plan
- Reset and idle: hold `rst_n` low, then release → `in_ready`=1, `out_valid`=0, `result`=0x00.
- Single-cycle ops, W=4, a=9, b=3, ops 0,1,2,3,5,6,7 issued back-to-back with `out_ready`=1 → results 0x0C, 0x06, 0x0F, 0x03, 0x03, 0x09, 0x03 on consecutive cycles, each 1 cycle after its accept.
- Multiply, W=4, a=15, b=15 → `in_ready`=0 for 4 cycles, `out_valid` in the 5th cycle after accept, `result`=0xE1.
- Back-pressure: ADD a=2, b=5 with `out_ready`=0 for 3 cycles → `result`=0x07 held and `in_ready`=0 throughout. Then `out_ready`=1 with a new ADD a=1, b=1 on the same edge → next `result`=0x02 and `out_valid` stays high.
- Underflow with `SEQ_ALU_FLAGS_EN`, W=4: SUB a=3, b=5 → `result`=0xFE, `flag_borrow`=1, `flag_zero`=0. SUB a=5, b=5 → `result`=0x00, `flag_zero`=1, `flag_borrow`=0.
- Reset mid-multiply: MUL a=7, b=6, pull `rst_n` low after 2 BUSY cycles, then release → IDLE, `out_valid` never asserted for that op, `result`=0x00.
